// File: rtl/main_ctr_fsm_if.sv
// Purpose: control/memory bundle between the main control FSM and the datapath/memory side.
// Latency: none, wires only.
// Backpressure: mem_req is held until mem_ack. The FSM stalls in FETCH/MEM until the ack or a timeout.
interface main_ctr_fsm_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       opcode;
    logic             mem_ack;
    logic [2:0]       alu_op;
    logic             alu_src_b;
    logic             reg_dst;
    logic             reg_write;
    logic             mem_to_reg;
    logic             mem_req;
    logic             mem_we;
    logic             ir_write;
    logic             pc_write;
    logic             pc_write_cond;
    logic             branch_ne;
    logic             illegal;
    logic             bus_err;
    logic [CNT_W-1:0] retired;

    // FSM side: consumes the IR opcode and the memory ack, drives every strobe.
    modport master (
        input  opcode, mem_ack,
        output alu_op, alu_src_b, reg_dst, reg_write, mem_to_reg,
               mem_req, mem_we, ir_write, pc_write, pc_write_cond,
               branch_ne, illegal, bus_err, retired
    );

    // Datapath/memory side: the mirror image.
    modport slave (
        output opcode, mem_ack,
        input  alu_op, alu_src_b, reg_dst, reg_write, mem_to_reg,
               mem_req, mem_we, ir_write, pc_write, pc_write_cond,
               branch_ne, illegal, bus_err, retired
    );
endinterface

// File: rtl/main_ctr_fsm.sv
// Purpose: multi-cycle main control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing, ALUop and datapath strobes.
// Latency: minimum CPI is J=2, BEQ/BNE=3, R/I-type=4, SW=4, LW=5 when mem_ack arrives in the first request cycle.
// Backpressure: waits in FETCH/MEM for mem_ack. After TIMEOUT unacked cycles it flags bus_err and refetches.
module main_ctr_fsm #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    main_ctr_fsm_if.master bus
);
    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;

    // ALUop codes are the low three opcode bits for opcodes 0..7.
    localparam logic [2:0] AOP_R   = 3'b000;
    localparam logic [2:0] AOP_LW  = 3'b100;
    localparam logic [2:0] AOP_SW  = 3'b101;
    localparam logic [2:0] AOP_BEQ = 3'b110;
    localparam logic [2:0] AOP_BNE = 3'b111;
    localparam logic [4:0] OP_J    = 5'b01000;

    localparam int              TMR_W    = $clog2(TIMEOUT + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    logic [2:0]       state_q, state_d;
    logic [2:0]       alu_op_q;
    logic             req_q;
    logic [TMR_W-1:0] timer_q;
    logic             illegal_q;
    logic             bus_err_q;
    logic [CNT_W-1:0] retired_q;

    logic ack_ok;
    logic wait_cyc;
    logic timeout;
    logic op_alu;
    logic op_j;
    logic is_r, is_lw, is_sw, is_beq, is_bne, is_branch, is_ldst;
    logic retire;
    logic set_illegal;

    // A mem_ack only counts while a request is outstanding.
    assign ack_ok   = req_q & bus.mem_ack;
    assign wait_cyc = req_q & ~bus.mem_ack;
    assign timeout  = wait_cyc && (timer_q == TMR_LAST);

    // Opcode decoding for DECODE. Opcodes 0..7 carry an ALUop. J has none. The rest are undefined.
    assign op_alu = (bus.opcode[4:3] == 2'b00);
    assign op_j   = (bus.opcode == OP_J);

    // EXEC/MEM/WB steer from the ALUop latched in DECODE.
    // This keeps their strobes independent of the live IR.
    assign is_r      = (alu_op_q == AOP_R);
    assign is_lw     = (alu_op_q == AOP_LW);
    assign is_sw     = (alu_op_q == AOP_SW);
    assign is_beq    = (alu_op_q == AOP_BEQ);
    assign is_bne    = (alu_op_q == AOP_BNE);
    assign is_branch = is_beq | is_bne;
    assign is_ldst   = is_lw | is_sw;

    // Next-state selection plus the retire / illegal events of this cycle.
    always_comb begin
        state_d     = state_q;
        retire      = 1'b0;
        set_illegal = 1'b0;
        case (state_q)
            S_FETCH: begin
                if (ack_ok) begin
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (op_j) begin
                    state_d = S_FETCH;
                    retire  = 1'b1;
                end else if (!op_alu) begin
                    state_d     = S_FETCH;
                    set_illegal = 1'b1;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (is_branch) begin
                    state_d = S_FETCH;
                    retire  = 1'b1;
                end else if (is_ldst) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                if (timeout) begin
                    state_d = S_FETCH;
                end else if (ack_ok) begin
                    if (is_sw) begin
                        state_d = S_FETCH;
                        retire  = 1'b1;
                    end else begin
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // State register. Reset lands in FETCH with no request outstanding.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // The request flop rises on entry to FETCH/MEM.
    // It falls for one cycle after an ack or a timeout.
    // This gives a fresh request edge after a refetch, and after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q <= 1'b0;
        end else begin
            req_q <= ((state_d == S_FETCH) || (state_d == S_MEM)) && !ack_ok && !timeout;
        end
    end

    // Ack timer: counts unacked request cycles. It clears whenever no wait is in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer_q <= '0;
        end else if (wait_cyc && !timeout) begin
            timer_q <= timer_q + 1'b1;
        end else begin
            timer_q <= '0;
        end
    end

    // ALUop latch: loaded in DECODE for opcodes that carry one. J and undefined opcodes hold it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_op_q <= 3'b000;
        end else if ((state_q == S_DECODE) && op_alu) begin
            alu_op_q <= bus.opcode[2:0];
        end
    end

    // Sticky error flags. Only reset clears them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            if (set_illegal) illegal_q <= 1'b1;
            if (timeout)     bus_err_q <= 1'b1;
        end
    end

    // Retired-instruction counter. It wraps naturally at 2^CNT_W.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired_q <= '0;
        end else if (retire) begin
            retired_q <= retired_q + 1'b1;
        end
    end

    assign bus.alu_op        = alu_op_q;
    assign bus.alu_src_b     = (state_q == S_EXEC) && !(is_r || is_branch);
    assign bus.reg_dst       = (state_q == S_WB) && is_r;
    assign bus.reg_write     = (state_q == S_WB);
    assign bus.mem_to_reg    = (state_q == S_WB) && is_lw;
    assign bus.mem_req       = req_q;
    assign bus.mem_we        = req_q && (state_q == S_MEM) && is_sw;
    assign bus.ir_write      = (state_q == S_FETCH) && ack_ok;
    assign bus.pc_write      = ((state_q == S_FETCH) && ack_ok) || ((state_q == S_DECODE) && op_j);
    assign bus.pc_write_cond = (state_q == S_EXEC) && is_branch;
    assign bus.branch_ne     = (state_q == S_EXEC) && is_bne;
    assign bus.illegal       = illegal_q;
    assign bus.bus_err       = bus_err_q;
    assign bus.retired       = retired_q;
endmodule
